// File: rtl/bus_responder_ram_if.sv
// Bus between a requester and bus_responder_ram.
//   busaddr   : byte address of the transfer
//   rd_req    : read request, held until rw_wait=0
//   wr_req    : write request, held until rw_wait=0
//   wr_data   : lane-replicated write data
//   data_size : 3'b001 byte, 3'b010 halfword, 3'b100 word
//   rw_wait   : stall; request with rw_wait=0 completes the transfer
//   rd_data   : full stored word at the addressed word index
//   bus_err   : sticky protocol-error flag
interface bus_responder_ram_if;
  logic [31:0] busaddr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [2:0]  data_size;
  logic        rw_wait;
  logic [31:0] rd_data;
  logic        bus_err;

  modport master (
    output busaddr, rd_req, wr_req, wr_data, data_size,
    input  rw_wait, rd_data, bus_err
  );

  modport slave (
    input  busaddr, rd_req, wr_req, wr_data, data_size,
    output rw_wait, rd_data, bus_err
  );
endinterface

// File: rtl/bus_responder_ram.sv
// Word-organised RAM behind a wait-state bus responder.
// Each transfer costs WAIT_CYCLES stall cycles, one completion cycle and one
// DONE stall cycle. Byte/halfword/word writes use per-byte lane enables;
// reads return the whole word combinationally while rd_req is high.
// Ports:
//   clk  : clock, rising edge
//   Nrst : asynchronous active-low reset
//   bus  : slave side of bus_responder_ram_if
module bus_responder_ram #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               Nrst,
  bus_responder_ram_if.slave bus
);

  localparam int unsigned DataW  = 32;
  localparam int unsigned LaneN  = 4;
  localparam int unsigned CntW   = 4;
  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned AddrHi = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;

  logic [DataW-1:0]    mem_q [Depth];

  logic                req_c;
  logic                bad_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                rw_wait_c;
  logic                complete_c;
  logic                wr_commit_c;
  logic [LaneN-1:0]    lane_en_c;
  logic                unused_addr_c;

  // Request decode
  assign req_c = bus.rd_req | bus.wr_req;
  assign bad_c = (bus.rd_req & bus.wr_req) |
                 ~((bus.data_size == 3'b001) | (bus.data_size == 3'b010) |
                   (bus.data_size == 3'b100));
  assign idx_c = bus.busaddr[AddrHi:2];

  // Address bits above the storage index wrap around
  assign unused_addr_c = ^bus.busaddr[DataW-1:AddrHi+1];

  // State register
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CntLoad;
          end
        end
      end
      ST_WAIT: begin
        // Dropping the request abandons the transfer
        if (!req_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall, completion, error and write-lane outputs
  always_comb begin
    rw_wait_c   = 1'b0;
    complete_c  = 1'b0;
    lane_en_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          rw_wait_c  = (WAIT_CYCLES != 0);
          complete_c = (WAIT_CYCLES == 0);
        end
      end
      ST_WAIT: begin
        if (req_c) begin
          rw_wait_c  = (cnt_q != '0);
          complete_c = (cnt_q == '0);
        end
      end
      ST_DONE: rw_wait_c = 1'b1;
      default: rw_wait_c = 1'b1;
    endcase
    if (!Nrst) begin
      rw_wait_c  = 1'b1;
      complete_c = 1'b0;
    end

    case (bus.data_size)
      3'b001:  lane_en_c = 4'b0001 << bus.busaddr[1:0];
      3'b010:  lane_en_c = bus.busaddr[1] ? 4'b1100 : 4'b0011;
      3'b100:  lane_en_c = 4'b1111;
      default: lane_en_c = 4'b0000;
    endcase

    bus_err_d   = bus_err_q | (complete_c & bad_c);
    wr_commit_c = complete_c & bus.wr_req & ~bad_c;
  end

  // Storage: written on the completion edge only, never reset
  always_ff @(posedge clk) begin
    if (wr_commit_c) begin
      for (int i = 0; i < int'(LaneN); i++) begin
        if (lane_en_c[i]) begin
          mem_q[idx_c][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read path is combinational; same-cycle writes are not forwarded
  assign bus.rd_data = (bus.rd_req && Nrst) ? mem_q[idx_c] : '0;
  assign bus.rw_wait = rw_wait_c;
  assign bus.bus_err = bus_err_q;

endmodule

// File: doc/bus_responder_ram.md
BUS_RESPONDER_RAM -- requirements
Module: bus_responder_ram

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 12, giving log2 of the number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state cycles inserted per transfer (legal range 0..15).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Nrst  input  1  reset, asynchronous assert, active-low.
REQ-005 busaddr  input  32  byte address of the transfer.
REQ-006 rd_req  input  1  read request, held by the requester until rw_wait=0.
REQ-007 wr_req  input  1  write request, held by the requester until rw_wait=0.
REQ-008 wr_data  input  32  write data, already lane-replicated by the requester.
REQ-009 data_size  input  3  transfer size: 3'b001 byte, 3'b010 halfword, 3'b100 word.
REQ-010 rw_wait  output  1  stall to requester; a cycle with a request and rw_wait=0 completes the transfer.
REQ-011 rd_data  output  32  unaligned full word at busaddr[DEPTH_LOG2+1:2], requester performs alignment.
REQ-012 bus_err  output  1  sticky protocol-error flag.

Function
REQ-013 Storage SHALL be 2^DEPTH_LOG2 words indexed by busaddr[DEPTH_LOG2+1:2]; higher address bits ignored (wrap-around).
REQ-014 FSM states SHALL be IDLE, WAIT, DONE, with a 4-bit wait counter.
REQ-015 IDLE with exactly one of rd_req/wr_req asserted: if WAIT_CYCLES=0, rw_wait=0 that cycle and next state DONE; else rw_wait=1, counter loads WAIT_CYCLES-1, next state WAIT.
REQ-016 WAIT: rw_wait=1 while counter is nonzero, counter decrements each cycle; at counter=0 rw_wait=0 and next state DONE.
REQ-017 DONE: rw_wait=1 for one cycle regardless of request, then IDLE; a request still held in DONE is treated as a new transfer starting in IDLE the following cycle (back-to-back transfers cost WAIT_CYCLES+2 cycles each).
REQ-018 A request deasserted while in WAIT SHALL abandon the transfer: no write, next state IDLE.
REQ-019 A write SHALL commit to storage only on the rising edge ending the completion cycle (request asserted, rw_wait=0).
REQ-020 Write lanes: byte writes lane busaddr[1:0]; halfword writes bytes 1:0 if busaddr[1]=0 else 3:2 (busaddr[0] ignored); word writes all four lanes.
REQ-021 rd_data SHALL equal the addressed stored word whenever rd_req=1 and Nrst=1, else 32'h0; a write to the same word in the same cycle is not forwarded.
REQ-022 rd_req and wr_req both asserted, or data_size not in {001,010,100} with a request, SHALL complete as a normal-length transfer with no write and set bus_err on the completion edge.
REQ-023 bus_err SHALL remain set until reset.
REQ-024 rw_wait SHALL be 0 in any cycle with no request and the state not DONE.

Reset
REQ-025 While Nrst=0: state IDLE, counter 0, bus_err 0, rd_data 32'h0, rw_wait 1, no writes.
REQ-026 Reset asserted mid-transfer SHALL abandon it without writing; after release a held request starts a fresh transfer from IDLE.
REQ-027 Storage contents SHALL NOT be affected by reset.

Verification
REQ-028 WAIT_CYCLES=2: word write 32'hDEADBEEF to 0x100, held req -> rw_wait 1,1,0, write on third edge; then word read 0x100 -> rd_data 32'hDEADBEEF on completion cycle.
REQ-029 Byte write wr_data 32'h5A5A5A5A size 001 to 0x103 over word 32'h00000000 -> read of 0x100 returns 32'h5A000000; halfword 32'h12341234 to 0x101 -> 32'h5A001234.
REQ-030 WAIT_CYCLES=0, four back-to-back word reads held continuously -> rw_wait pattern 0,1 repeating, four completions in 8 cycles.
REQ-031 rd_req and wr_req both high to 0x0 -> transfer completes after 2 wait cycles, word 0x0 unchanged, bus_err 1 from the completion edge.
REQ-032 Nrst pulsed low during WAIT of a write to 0x200 -> word 0x200 unchanged, bus_err 0, after release transfer restarts with full wait count.
REQ-033 Write to 0x0 then read of (1<<(DEPTH_LOG2+2)) -> returns the word written at 0x0 (wrap).
